// File: rtl/rate_tick_counter.sv
// Rate-selectable tick generator driving a bounded up/down counter.
// Tick period is BASE_DIV >> select cycles (minimum 1); count updates on tick edges.
module rate_tick_counter #(
    parameter int DIV_W    = 26,
    parameter int BASE_DIV = 50000000,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 4,
    parameter int CNT_MAX  = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [SEL_W-1:0] select,
    input  logic             up,
    input  logic             wrap_mode,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             wrapped,
    output logic             at_limit
);

    localparam logic [31:0]      BASE_DIV_V = 32'(BASE_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX_V  = CNT_W'(CNT_MAX);

    logic [DIV_W-1:0] div_cnt;

    // Reload value for the divider: period minus one, with the period floored at 1.
    function automatic logic [DIV_W-1:0] period_m1(input logic [SEL_W-1:0] sel);
        logic [31:0] p;
        p = BASE_DIV_V >> sel;
        if (p == 32'd0) begin
            p = 32'd1;
        end
        return DIV_W'(p - 32'd1);
    endfunction

    function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] v);
        return (v > CNT_MAX_V) ? CNT_MAX_V : v;
    endfunction

    // Returns {wrap_event, next_count} for one counting step at the bounds [0, CNT_MAX].
    function automatic logic [CNT_W:0] step_count(
        input logic [CNT_W-1:0] c,
        input logic             dir_up,
        input logic             wrap_en
    );
        if (dir_up) begin
            if (c < CNT_MAX_V) begin
                return {1'b0, c + 1'b1};
            end else if (wrap_en) begin
                return {1'b1, {CNT_W{1'b0}}};
            end else begin
                return {1'b0, c};
            end
        end else begin
            if (c != {CNT_W{1'b0}}) begin
                return {1'b0, c - 1'b1};
            end else if (wrap_en) begin
                return {1'b1, CNT_MAX_V};
            end else begin
                return {1'b0, c};
            end
        end
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= period_m1(select);
            count   <= '0;
            tick    <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            tick    <= 1'b0;
            wrapped <= 1'b0;
            if (enable) begin
                if (div_cnt == '0) begin
                    // select is only sampled here, so a mid-period change never truncates a period
                    div_cnt <= period_m1(select);
                    tick    <= 1'b1;
                    if (!load) begin
                        {wrapped, count} <= step_count(count, up, wrap_mode);
                    end
                end else begin
                    div_cnt <= div_cnt - 1'b1;
                end
            end
            // Load leaves div_cnt untouched so the tick phase is preserved.
            if (load) begin
                count <= clamp_load(load_val);
            end
        end
    end

    assign at_limit = (up && (count == CNT_MAX_V)) || (!up && (count == '0));

endmodule

// File: tb/tb_rate_tick_counter.sv
// Bench for rate_tick_counter: directed scenarios then random traffic, all checked
// every cycle against a period/elapsed-cycle reference model.
module tb_rate_tick_counter;

    localparam int DIV_W    = 4;
    localparam int BASE_DIV = 8;
    localparam int SEL_W    = 2;
    localparam int CNT_W    = 5;
    localparam int CNT_MAX  = 15;

    logic             clock = 1'b0;
    logic             reset, enable, up, wrap_mode, load;
    logic [SEL_W-1:0] select;
    logic [CNT_W-1:0] load_val;
    logic             tick, wrapped, at_limit;
    logic [CNT_W-1:0] count;

    int tests = 0;
    int fails = 0;

    // Reference model state: cycles elapsed in the current period and its length.
    int m_elapsed, m_period, m_count;
    bit m_tick, m_wrapped;

    always #5 clock = ~clock;

    rate_tick_counter #(
        .DIV_W(DIV_W), .BASE_DIV(BASE_DIV), .SEL_W(SEL_W),
        .CNT_W(CNT_W), .CNT_MAX(CNT_MAX)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .select(select),
        .up(up), .wrap_mode(wrap_mode), .load(load), .load_val(load_val),
        .tick(tick), .count(count), .wrapped(wrapped), .at_limit(at_limit)
    );

    function automatic int period_of(input int s);
        int p;
        p = BASE_DIV >> s;
        return (p == 0) ? 1 : p;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_elapsed = 0;
            m_period  = period_of(int'(select));
            m_count   = 0;
            m_tick    = 0;
            m_wrapped = 0;
            return;
        end
        m_tick    = 0;
        m_wrapped = 0;
        if (enable) begin
            m_elapsed++;
            if (m_elapsed >= m_period) begin
                m_tick    = 1;
                m_elapsed = 0;
                m_period  = period_of(int'(select));
                if (!load) begin
                    if (up) begin
                        if (m_count < CNT_MAX) m_count++;
                        else if (wrap_mode) begin m_count = 0; m_wrapped = 1; end
                    end else begin
                        if (m_count > 0) m_count--;
                        else if (wrap_mode) begin m_count = CNT_MAX; m_wrapped = 1; end
                    end
                end
            end
        end
        if (load) m_count = (int'(load_val) > CNT_MAX) ? CNT_MAX : int'(load_val);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input logic [CNT_W-1:0] obs, input int exp);
        tests++;
        assert (obs === CNT_W'(exp)) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_at_limit();
        return (up && m_count == CNT_MAX) || (!up && m_count == 0);
    endfunction

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        check_bit("tick", tick, m_tick);
        check_int("count", count, m_count);
        check_bit("wrapped", wrapped, m_wrapped);
        check_bit("at_limit", at_limit, model_at_limit());
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    // Advance (bounded) until the next enabled edge is a tick edge.
    task automatic align_to_tick();
        for (int i = 0; i < 40 && (m_elapsed != m_period - 1); i++) cyc();
        tests++;
        assert (m_elapsed == m_period - 1) else begin
            fails++;
            $error("FAIL align_timeout observed=%0d expected=%0d", m_elapsed, m_period - 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; select = '0; up = 1'b1;
        wrap_mode = 1'b1; load = 1'b0; load_val = '0;
        run(2);
        check_int("reset_count", count, 0);
        reset = 1'b0;

        // Full up-count with wrap at select=0 (period 8)
        run(8 * 17);

        // P=1: tick every cycle, then back to 8 and a mid-period switch to 2
        select = 2'd3;
        run(6);
        select = 2'd0;
        run(3);
        select = 2'd2;
        run(14);

        // Saturate at the top
        wrap_mode = 1'b0;
        load = 1'b1; load_val = 5'd14;
        cyc();
        load = 1'b0;
        run(10);
        up = 1'b0;
        #1;
        check_bit("at_limit_dir", at_limit, model_at_limit());
        run(2);

        // Wrap at the bottom
        wrap_mode = 1'b1;
        load = 1'b1; load_val = 5'd0;
        cyc();
        load = 1'b0;
        run(4);

        // Load clamp
        load = 1'b1; load_val = 5'd20;
        cyc();
        load = 1'b0;
        check_int("load_clamp", count, CNT_MAX);

        // Enable pause mid-period
        select = 2'd0; up = 1'b1;
        run(11);
        enable = 1'b0;
        run(5);
        load = 1'b1; load_val = 5'd7;
        cyc();
        load = 1'b0;
        enable = 1'b1;
        run(12);

        // Load coinciding with a tick edge
        align_to_tick();
        load = 1'b1; load_val = 5'd3;
        cyc();
        load = 1'b0;
        check_int("load_on_tick", count, 3);
        check_bit("load_on_tick_tick", tick, 1'b1);

        // Reset coinciding with a tick edge
        align_to_tick();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        run(10);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom % 60) == 0;
            enable    = ($urandom % 8) != 0;
            select    = SEL_W'($urandom_range(0, 3));
            up        = ($urandom % 3) != 0;
            wrap_mode = $urandom % 2;
            load      = ($urandom % 16) == 0;
            load_val  = CNT_W'($urandom_range(0, 31));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rate_tick_counter.md
Name: rate_tick_counter

Overview:
- Parametrised successor to the fixed four-speed divider/display-counter pair.
- Generates a single-cycle tick (clock enable, not a derived clock) at a selectable rate of BASE_DIV >> select cycles.
- Drives a configurable up/down counter with wrap or saturate mode, synchronous load, and rollover/limit flags.
- Feeds beat timing and score/step displays in the rhythm game; all logic runs in the single system clock domain.

Parameters:
- DIV_W, 26, width of the divider down-counter; must satisfy BASE_DIV <= 2^DIV_W.
- BASE_DIV, 50000000, period in clock cycles at select=0.
- SEL_W, 2, select width; period = BASE_DIV >> select.
- CNT_W, 4, width of count output.
- CNT_MAX, 15, counter upper bound; must be <= 2^CNT_W - 1. Lower bound is 0.

Ports:
- clock  input  1  system clock (CLOCK_50 at top); all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = divider runs; 0 = divider and counter frozen.
- select  input  SEL_W  rate select; period = max(1, BASE_DIV >> select).
- up  input  1  count direction: 1 = increment, 0 = decrement.
- wrap_mode  input  1  1 = wrap at bounds; 0 = saturate at bounds.
- load  input  1  synchronous load of load_val into count.
- load_val  input  CNT_W  load value, clamped to CNT_MAX.
- tick  output  1  registered, one-cycle pulse each elapsed period.
- count  output  CNT_W  registered counter value.
- wrapped  output  1  registered, one-cycle pulse on a wrap event.
- at_limit  output  1  combinational: (up && count==CNT_MAX) || (!up && count==0).

Behaviour:
- P(sel) = BASE_DIV >> sel; if the result is 0, P = 1. Compute it combinationally from select.
- Reset (reset=1 at an edge, overrides everything):
  - div_cnt <= P(select)-1, count <= 0, tick <= 0, wrapped <= 0.
  - After reset, at_limit = 1 when up=0, and 0 when up=1 (assuming CNT_MAX > 0).
- Divider, when enable=1:
  - div_cnt != 0: div_cnt <= div_cnt-1, tick <= 0.
  - div_cnt == 0: div_cnt <= P(select)-1, tick <= 1.
  - Tick spacing is therefore exactly P cycles. With P=1, tick is held high every enabled cycle.
- Divider, when enable=0: div_cnt holds, tick <= 0, wrapped <= 0, count holds (load is still honoured).
- Rate change: select is sampled only at reload. A change mid-period does not truncate the current period; the new period starts with the next one. No glitch or extra tick.
- Counter update happens on the same edge that sets tick=1, so the new count is visible in the same cycle tick is high.
  - up=1, count<CNT_MAX: count+1.
  - up=1, count==CNT_MAX: wrap_mode=1 -> 0 and wrapped <= 1; wrap_mode=0 -> hold, wrapped <= 0.
  - up=0, count>0: count-1.
  - up=0, count==0: wrap_mode=1 -> CNT_MAX and wrapped <= 1; wrap_mode=0 -> hold.
  - On all non-wrap edges, wrapped <= 0.
- Load:
  - load=1 sets count <= min(load_val, CNT_MAX), regardless of enable.
  - If load coincides with a counting tick, load wins: no increment, wrapped <= 0, but tick still pulses.
  - Load does not touch div_cnt, so period phase is preserved.
- up/wrap_mode are sampled on the updating edge; changing them between ticks has no side effects.
- Reset mid-period discards the partial period; the first tick after reset release occurs P(select) cycles later (counting the first enabled edge after reset as cycle 1).
- Arithmetic is unsigned. No overflow beyond CNT_MAX is ever stored.

Test Plan:
- BASE_DIV=8, SEL_W=2, CNT_MAX=15, select=0, enable=1, up=1, wrap_mode=1, reset pulse -> tick every 8 cycles; count 0,1,...,15,0. On the 15->0 edge, wrapped=1 for exactly one cycle.
- select=3 (P=1) -> tick high every cycle, count advances every cycle. Switch select 0->2 mid-period -> current 8-cycle period completes, then ticks every 2 cycles.
- wrap_mode=0, up=1, load=1 load_val=14 -> count=14; after 2 ticks count=15 and holds, at_limit=1, wrapped never asserts. Set up=0 -> at_limit=0; next tick count=14.
- up=0, wrap_mode=1, count=0, tick -> count=15, wrapped=1. load_val=20 with CNT_MAX=15 -> count=15 (clamped).
- enable=0 for 5 cycles mid-period -> tick stays 0 and count holds; on re-enable the period resumes, with total tick spacing = 8 + 5 cycles.
- load asserted on a tick edge with load_val=3 -> count=3, tick=1, wrapped=0. Reset asserted on a tick edge -> count=0, tick=0, next tick P cycles later.
